// File: rtl/fifo_drain_ctrl_if.sv
// Handshake/bus bundle between the drain controller, its FIFO and the downstream consumer.
// slave = controller side, master = FIFO/writer/consumer side.
interface fifo_drain_ctrl_if #(
  parameter int DATA_LEN   = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  flush;
  logic                  fifo_wr_en;
  logic                  fifo_rd_en;
  logic [DATA_LEN-1:0]   fifo_data;
  logic [DATA_LEN-1:0]   m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [ADDR_WIDTH:0]   level;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  overflow;

  modport slave (
    input  flush, fifo_wr_en, fifo_data, m_ready,
    output fifo_rd_en, m_data, m_valid, level, fifo_empty, fifo_full, overflow
  );

  modport master (
    output flush, fifo_wr_en, fifo_data, m_ready,
    input  fifo_rd_en, m_data, m_valid, level, fifo_empty, fifo_full, overflow
  );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Read-side controller for a flagless sync FIFO: shadow occupancy, registered rd_en,
// 2-entry skid buffer streaming words out on valid/ready.
module fifo_drain_ctrl #(
  parameter int DATA_LEN   = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic              clk,
  input  logic              sys_rst,
  fifo_drain_ctrl_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic                  rd_en_q, rd_en_d;
  logic                  inflight_q;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [DATA_LEN-1:0]   head_q, head_d;
  logic [DATA_LEN-1:0]   tail_q, tail_d;
  logic                  accept;

  assign accept = (buf_cnt_q != 2'd0) && bus.m_ready;

  // Shadow occupancy: the FIFO itself has no flags, so mirror its write/read pointers' distance.
  always_comb begin
    level_d = level_q;
    ovf_d   = ovf_q;
    case ({bus.fifo_wr_en, rd_en_q})
      2'b10: begin
        if (level_q == FULL_LVL) ovf_d = 1'b1;
        else                     level_d = level_q + 1'b1;
      end
      2'b01: begin
        if (level_q != '0) level_d = level_q - 1'b1;
      end
      default: ;
    endcase
  end

  // Skid buffer: head feeds m_data, tail only holds a word while the head is stalled.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    buf_cnt_d = buf_cnt_q;
    case ({accept, inflight_q})
      2'b10: begin
        if (buf_cnt_q == 2'd2) head_d = tail_q;
        buf_cnt_d = buf_cnt_q - 1'b1;
      end
      2'b01: begin
        if (buf_cnt_q == 2'd0) head_d = bus.fifo_data;
        else                   tail_d = bus.fifo_data;
        buf_cnt_d = buf_cnt_q + 1'b1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          head_d = bus.fifo_data;
        end else begin
          head_d = tail_q;
          tail_d = bus.fifo_data;
        end
      end
      default: ;
    endcase
  end

  // A new read lands two edges from now; only issue it if a slot is guaranteed even with no accepts.
  always_comb begin
    rd_en_d = (level_d != '0) && ((buf_cnt_d + 2'(rd_en_q)) < 2'd2);
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      level_q    <= '0;
      ovf_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else if (bus.flush) begin
      level_q    <= '0;
      ovf_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      rd_en_q    <= rd_en_d;
      inflight_q <= rd_en_q;
      buf_cnt_q  <= buf_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  assign bus.fifo_rd_en = rd_en_q;
  assign bus.m_data     = head_q;
  assign bus.m_valid    = (buf_cnt_q != 2'd0);
  assign bus.level      = level_q;
  assign bus.fifo_empty = (level_q == '0);
  assign bus.fifo_full  = (level_q == FULL_LVL);
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: plays the FIFO and writer, keeps a queue-based model of
// FIFO contents and skid buffer, and checks every cycle plus directed literal expectations.
module tb_fifo_drain_ctrl;
  localparam int DL = 8;
  localparam int DP = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 clk = ~clk;

  fifo_drain_ctrl_if #(.DATA_LEN(DL), .ADDR_WIDTH(AW)) bus();

  fifo_drain_ctrl #(.DATA_LEN(DL), .DEPTH(DP), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] fq[$];    // contents of the FIFO
  logic [7:0] mbuf[$];  // words the controller holds for downstream
  logic [7:0] sb[$];    // every word accepted by the FIFO, in write order
  bit   mrd, minfl, movf;
  bit   chk_en = 1'b0;
  logic [7:0] wd = '0;
  int   acc_cnt = 0;
  logic [7:0] last_acc = '0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.fifo_wr_en = 1'b1;
    wd = d;
    step();
    bus.fifo_wr_en = 1'b0;
  endtask

  // FIFO + reference model, advanced on every active edge
  initial forever begin
    @(posedge clk or posedge sys_rst);
    if (sys_rst || bus.flush) begin
      fq.delete(); mbuf.delete(); sb.delete();
      mrd = 1'b0; minfl = 1'b0; movf = 1'b0;
      bus.fifo_data <= '0;
    end else begin
      bit acc;
      acc = (mbuf.size() != 0) && bus.m_ready;
      if (acc) void'(mbuf.pop_front());
      if (minfl) mbuf.push_back(bus.fifo_data);
      if (bus.fifo_rd_en && fq.size() != 0) bus.fifo_data <= fq.pop_front();
      if (bus.fifo_wr_en) begin
        if (fq.size() < DP) begin
          fq.push_back(wd);
          sb.push_back(wd);
        end else movf = 1'b1;
      end
      minfl = mrd;
      mrd = (fq.size() != 0) && ((mbuf.size() + minfl) < 2);
    end
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("rd_en", bus.fifo_rd_en, mrd);
      chk("m_valid", bus.m_valid, mbuf.size() != 0);
      if (mbuf.size() != 0) chk("m_data", bus.m_data, mbuf[0]);
      chk("level", bus.level, fq.size());
      chk("empty", bus.fifo_empty, fq.size() == 0);
      chk("full", bus.fifo_full, fq.size() == DP);
      chk("overflow", bus.overflow, movf);
      if (bus.m_valid && bus.m_ready && !bus.flush) begin
        acc_cnt++;
        last_acc = bus.m_data;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_extra: got %0h want none at %0t", bus.m_data, $time);
        end else chk("order", bus.m_data, sb.pop_front());
      end
    end
  end

  initial begin
    int base, rd_cnt;
    bit hit;
    bus.flush = 1'b0; bus.fifo_wr_en = 1'b0; bus.m_ready = 1'b0; bus.fifo_data = '0;
    repeat (3) step();
    chk("rst_level", bus.level, 0);
    chk("rst_empty", bus.fifo_empty, 1);
    chk("rst_rd", bus.fifo_rd_en, 0);
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_data", bus.m_data, 0);
    chk("rst_ovf", bus.overflow, 0);
    sys_rst = 1'b0;
    chk_en = 1'b1;
    step();

    // streaming 0x11..0x18 with latency pinned
    bus.m_ready = 1'b1;
    base = acc_cnt;
    for (int i = 0; i < 8; i++) begin
      wr(8'h11 + 8'(i));
      if (i == 0) begin chk("lat_level", bus.level, 1); chk("lat_rd", bus.fifo_rd_en, 1); end
      if (i == 1) chk("lat_valid0", bus.m_valid, 0);
      if (i == 2) begin chk("lat_valid1", bus.m_valid, 1); chk("lat_data", bus.m_data, 8'h11); end
    end
    repeat (30) step();
    chk("t2_count", acc_cnt - base, 8);
    chk("t2_last", last_acc, 8'h18);

    // stalled fill: only two reads fit the skid buffer
    bus.m_ready = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      wr(8'h31 + 8'(i));
      if (bus.fifo_rd_en) rd_cnt++;
    end
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.fifo_rd_en) rd_cnt++;
    end
    chk("t3_rd_pulses", rd_cnt, 2);
    chk("t3_level", bus.level, 6);
    chk("t3_valid", bus.m_valid, 1);
    chk("t3_head", bus.m_data, 8'h31);
    bus.m_ready = 1'b1;
    repeat (30) step();
    chk("t3_drained", sb.size(), 0);

    // saturation and sticky overflow
    bus.m_ready = 1'b0;
    for (int i = 0; i < 11; i++) wr(8'h40 + 8'(i));
    step();
    chk("t4_level", bus.level, 8);
    chk("t4_full", bus.fifo_full, 1);
    chk("t4_ovf", bus.overflow, 1);
    bus.m_ready = 1'b1;
    repeat (30) step();
    chk("t4_ovf_sticky", bus.overflow, 1);
    chk("t4_level0", bus.level, 0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("t4_ovf_clr", bus.overflow, 0);

    // write coinciding with a read at level 3
    for (int i = 0; i < 5; i++) wr(8'h60 + 8'(i));
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (bus.level == 3 && bus.fifo_rd_en) begin
        wr(8'h70);
        chk("t5_level", bus.level, 3);
        hit = 1'b1;
      end else if (bus.level < 3) wr(8'h68 + 8'(i));
      else step();
    end
    if (!hit) begin
      total++; bad++;
      $display("FAIL t5_timeout: got none want level3_with_rd");
    end

    // random traffic and backpressure
    for (int i = 0; i < 500; i++) begin
      bus.m_ready = ($urandom_range(0, 3) != 0);
      bus.fifo_wr_en = ($urandom_range(0, 1) == 1) && (fq.size() < DP);
      wd = 8'($urandom);
      step();
    end
    bus.fifo_wr_en = 1'b0;
    bus.m_ready = 1'b1;
    repeat (30) step();
    chk("rand_drained", sb.size(), 0);

    // flush mid-pipeline, then a single fresh word
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(8'h90 + 8'(i));
    step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("t6_valid", bus.m_valid, 0);
    chk("t6_level", bus.level, 0);
    chk("t6_data", bus.m_data, 0);
    step();
    wr(8'hA5);
    bus.m_ready = 1'b1;
    base = acc_cnt;
    repeat (10) step();
    chk("t6_count", acc_cnt - base, 1);
    chk("t6_word", last_acc, 8'hA5);

    // asynchronous reset mid-stream
    bus.m_ready = 1'b0;
    for (int i = 0; i < 7; i++) wr(8'hC0 + 8'(i));
    repeat (4) step();
    chk("t1_level5", bus.level, 5);
    chk("t1_valid1", bus.m_valid, 1);
    sys_rst = 1'b1;
    #1;
    chk("t1_level", bus.level, 0);
    chk("t1_valid", bus.m_valid, 0);
    chk("t1_rd", bus.fifo_rd_en, 0);
    step(); step();
    sys_rst = 1'b0;
    bus.m_ready = 1'b1;
    base = acc_cnt;
    repeat (10) step();
    chk("t1_no_out", acc_cnt - base, 0);
    chk("t1_valid_after", bus.m_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
